// File: rtl/spike_aer_encoder_if.sv
// AER event stream between the spike encoder (master) and the readout logic (slave).
// Carries one {address, timestamp} event per valid/ready handshake.
interface spike_aer_encoder_if #(
  parameter int ADDR_W = 2,
  parameter int TS_W   = 8
);
  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] ev_addr;
  logic [TS_W-1:0]   ev_ts;

  modport master (output ev_valid, output ev_addr, output ev_ts, input ev_ready);
  modport slave  (input ev_valid, input ev_addr, input ev_ts, output ev_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Serializes per-neuron spike pulses into timestamped AER events through a small FIFO.
// Optional feature macro: SPIKE_AER_TIMESTAMP_EN (timestamp counter and ts storage).
module spike_aer_encoder #(
  parameter int N_NEURONS  = 3,
  parameter int ADDR_W     = 2,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 clear,
  spike_aer_encoder_if.master  ev,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] pending_nxt;
  logic [N_NEURONS-1:0] capture;
  logic [N_NEURONS-1:0] drop_vec;
  logic [N_NEURONS-1:0] drained;

  logic              sel_valid;
  logic [ADDR_W-1:0] sel_idx;
  logic              pop;
  logic              push;
  logic              full;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];

  logic [4:0]        drop_cnt;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_base;
  logic [7:0]        drop_count_nxt;
  logic              overflow_nxt;

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_W-1:0]   ts;
  logic [TS_W-1:0]   pend_ts [N_NEURONS];
  logic [TS_W-1:0]   fifo_ts [FIFO_DEPTH];
`endif

  // Fixed-priority arbiter: lowest-index pending neuron wins the single push slot.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid = 1'b1;
        sel_idx   = ADDR_W'(i);
      end
    end
  end

  assign ev.ev_valid = (count != '0);
  assign pop         = ev.ev_valid && ev.ev_ready;
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign push        = sel_valid && (!full || pop);

  // A drained neuron may recapture in the same cycle; only an undrained pending slot drops.
  always_comb begin
    pending_nxt = pending;
    capture     = '0;
    drop_vec    = '0;
    drained     = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      drained[i] = push && (sel_idx == ADDR_W'(i));
      if (spike_in[i]) begin
        if (drained[i] || !pending[i]) begin
          pending_nxt[i] = 1'b1;
          capture[i]     = 1'b1;
        end else begin
          drop_vec[i] = 1'b1;
        end
      end else if (drained[i]) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      drop_cnt = drop_cnt + 5'(drop_vec[i]);
    end
    drop_base      = clear ? 8'd0 : drop_count;
    drop_sum       = {1'b0, drop_base} + 9'(drop_cnt);
    drop_count_nxt = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    overflow_nxt   = (clear ? 1'b0 : overflow) | (drop_vec != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      drop_count <= drop_count_nxt;
      overflow   <= overflow_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // FIFO storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sel_idx;
`ifdef SPIKE_AER_TIMESTAMP_EN
      fifo_ts[wr_ptr]   <= pend_ts[sel_idx];
`endif
    end
  end

  assign ev.ev_addr = ev.ev_valid ? fifo_addr[rd_ptr] : '0;

`ifdef SPIKE_AER_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pend_ts[i] <= '0;
      end
    end else begin
      ts <= ts + TS_W'(1);
      for (int i = 0; i < N_NEURONS; i++) begin
        if (capture[i]) begin
          pend_ts[i] <= ts;
        end
      end
    end
  end

  assign ev.ev_ts = ev.ev_valid ? fifo_ts[rd_ptr] : '0;
`else
  assign ev.ev_ts = {TS_W{1'b0}};
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: directed spike patterns push expected events,
// a negedge monitor pops and compares every accepted event.
module tb_spike_aer_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] spike_in;
  logic       clear;
  logic       overflow;
  logic [7:0] drop_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] tb_ts;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] ts;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  spike_aer_encoder_if #(.ADDR_W(2), .TS_W(8)) ev_if ();

  spike_aer_encoder #(
    .N_NEURONS(3), .ADDR_W(2), .TS_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spike_in(spike_in),
    .clear(clear),
    .ev(ev_if),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference timestamp: counts edges since reset release, wrapping at 8 bits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 8'd0;
    else        tb_ts <= tb_ts + 8'd1;
  end

  function automatic logic [7:0] exp_ts(input logic [7:0] t);
`ifdef SPIKE_AER_TIMESTAMP_EN
    return t;
`else
    return 8'd0;
`endif
  endfunction

  // Monitor: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event: got addr=%0d ts=%0d at cycle %0d, required no event",
                 ev_if.ev_addr, ev_if.ev_ts, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ev_if.ev_addr !== e.addr || ev_if.ev_ts !== e.ts || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("[TB] FAIL event: got addr=%0d ts=%0d cycle=%0d, required addr=%0d ts=%0d cycle=%0d",
                   ev_if.ev_addr, ev_if.ev_ts, cyc, e.addr, e.ts, e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] s, input logic r, input logic c);
    spike_in        = s;
    ev_if.ev_ready  = r;
    clear           = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [1:0] a, input logic [7:0] t, input int c);
    exp_t e;
    e.addr = a;
    e.ts   = exp_ts(t);
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (sb.size() != 0 && budget < 60) begin
      applyStimulus(3'b000, 1'b1, 1'b0);
      budget++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d events outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic doReset(input logic [2:0] s);
    spike_in       = s;
    ev_if.ev_ready = 1'b1;
    clear          = 1'b0;
    rst_n          = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    spike_in = 3'b000;
    rst_n    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    logic [7:0] t;

    // Reset with spikes asserted: nothing may leak through.
    doReset(3'b111);
    checkOutput("rst_valid", ev_if.ev_valid, 0);
    checkOutput("rst_addr", ev_if.ev_addr, 0);
    checkOutput("rst_ts", ev_if.ev_ts, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_drop_count", drop_count, 0);
    releaseReset();
    for (int k = 0; k < 10; k++) applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("idle_valid", ev_if.ev_valid, 0);

    // Single spike on neuron 1 at ts=5: visible two edges later for exactly one cycle.
    doReset(3'b000);
    releaseReset();
    while (tb_ts != 8'd5) applyStimulus(3'b000, 1'b1, 1'b0);
    c = cyc;
    pushExp(2'd1, 8'd5, c + 2);
    applyStimulus(3'b010, 1'b1, 1'b0);
    checkOutput("single_valid_e1", ev_if.ev_valid, 0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("single_valid_e2", ev_if.ev_valid, 1);
    checkOutput("single_addr", ev_if.ev_addr, 1);
    checkOutput("single_ts", ev_if.ev_ts, exp_ts(8'd5));
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("single_valid_e3", ev_if.ev_valid, 0);
    waitDrain();

    // Simultaneous spikes at ts=20: back-to-back events in index order.
    doReset(3'b000);
    releaseReset();
    while (tb_ts != 8'd20) applyStimulus(3'b000, 1'b1, 1'b0);
    c = cyc;
    pushExp(2'd0, 8'd20, c + 2);
    pushExp(2'd1, 8'd20, c + 3);
    pushExp(2'd2, 8'd20, c + 4);
    applyStimulus(3'b111, 1'b1, 1'b0);
    waitDrain();
    checkOutput("simul_drop_count", drop_count, 0);

    // Backpressure: 4 queued, 1 pending, 3 dropped; head frozen until ready rises.
    doReset(3'b000);
    releaseReset();
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    t = tb_ts;
    for (int k = 0; k < 8; k++) applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("bp_valid", ev_if.ev_valid, 1);
    checkOutput("bp_addr", ev_if.ev_addr, 0);
    checkOutput("bp_ts", ev_if.ev_ts, exp_ts(t));
    checkOutput("bp_drop_count", drop_count, 3);
    checkOutput("bp_overflow", overflow, 1);
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("bp_addr_hold", ev_if.ev_addr, 0);
    checkOutput("bp_ts_hold", ev_if.ev_ts, exp_ts(t));
    for (int k = 0; k < 5; k++) pushExp(2'd0, t + 8'(k), -1);
    waitDrain();
    checkOutput("bp_empty", ev_if.ev_valid, 0);

    // Timestamp wrap on neuron 2: ts 255 followed by ts 0 via drain-and-recapture.
    doReset(3'b000);
    releaseReset();
    while (tb_ts != 8'd255) applyStimulus(3'b000, 1'b1, 1'b0);
    c = cyc;
    pushExp(2'd2, 8'd255, c + 2);
    pushExp(2'd2, 8'd0, c + 3);
    applyStimulus(3'b100, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b1, 1'b0);
    waitDrain();
    checkOutput("wrap_drop_count", drop_count, 0);

    // Saturation: 8 drops while the FIFO fills, then 3 per cycle.
    doReset(3'b000);
    releaseReset();
    for (int k = 0; k < 10; k++) applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("sat_partial", drop_count, 23);
    for (int k = 0; k < 95; k++) applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("sat_count", drop_count, 255);
    checkOutput("sat_overflow", overflow, 1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkOutput("clear_count", drop_count, 0);
    checkOutput("clear_overflow", overflow, 0);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkOutput("clear_drop_count", drop_count, 1);
    checkOutput("clear_drop_overflow", overflow, 1);

    // Reset with a full FIFO and pending events: nothing emerges afterwards.
    doReset(3'b000);
    releaseReset();
    for (int k = 0; k < 10; k++) applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("midrst_valid", ev_if.ev_valid, 0);
    checkOutput("midrst_drop_count", drop_count, 0);
    checkOutput("midrst_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Collects per-cycle spike pulses from a bank of LIF neurons and serializes them into address-event representation (AER) words, each tagged with the cycle on which the spike was captured. It sits directly downstream of the neuron instances, taking their `spike` outputs, and feeds a valid/ready event stream toward the pin-level readout logic. A small FIFO absorbs bursts, and lost events are counted rather than silently discarded.

## Interface
Parameters:
- `N_NEURONS`, 3, number of spike inputs (1..16)
- `ADDR_W`, 2, event address width; must satisfy 2^ADDR_W ≥ N_NEURONS
- `TS_W`, 8, timestamp width
- `FIFO_DEPTH`, 4, event FIFO entries (power of two, ≥ 2)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `spike_in`  in  N_NEURONS  one bit per neuron; each cycle high is one spike event
- `clear`  in  1  synchronous; zeroes `drop_count` and `overflow`
- `ev_valid`  out  1  FIFO head holds an event
- `ev_ready`  in  1  consumer accepts the head event when `ev_valid && ev_ready`
- `ev_addr`  out  ADDR_W  neuron index of the head event
- `ev_ts`  out  TS_W  capture timestamp of the head event
- `overflow`  out  1  sticky; set on any dropped event
- `drop_count`  out  8  dropped events, saturating at 255

## Operation
- **Timestamp counter `ts`:**
  - Free-running.
  - +1 per cycle, wraps from 2^TS_W−1 to 0.
- **Capture:**
  - For each neuron i, if `spike_in[i]`=1 and `pending[i]`=0 at an edge, set `pending[i]` and latch `pend_ts[i]` = current `ts`.
- **Collision:**
  - Applies when `spike_in[i]`=1, `pending[i]`=1, and i is not being drained this cycle.
  - The new event is dropped.
  - `drop_count` +1 (saturating at 255); `overflow` ← 1.
  - The original pending event and its timestamp are kept.
  - Multiple collisions in one cycle count as one each, still saturating.
- **Drain (arbiter):**
  - Each cycle, pick the lowest-index set `pending` bit.
  - Push {i, `pend_ts[i]`} into the FIFO if a push is allowed, and clear `pending[i]`.
  - At most one push per cycle.
- **Drain-and-recapture:** if neuron i is drained this cycle and `spike_in[i]`=1 in the same cycle, `pending[i]` stays set with the new `ts`. This is not a drop.
- **Push allowed:** FIFO not full, or full with a pop in the same cycle.
- **Pop:** when `ev_valid && ev_ready`. A pop from an empty FIFO never happens, since `ev_valid`=0 when empty.
- **Simultaneous push and pop:** occupancy is unchanged. On an empty FIFO, a push is not visible until the next cycle (no fall-through).
- **Outputs:**
  - `ev_addr`/`ev_ts` are driven from the FIFO head.
  - They are held stable while `ev_valid && !ev_ready`.
  - Their value is don't-care only when `ev_valid`=0; implement them as zero in that case.
- **`clear`:**
  - Affects only `drop_count` and `overflow`.
  - A drop in the same cycle as `clear` wins: the result is count=1, overflow=1.

## Timing
- **Reset values (async assert):** `ev_valid`=0, `ev_addr`=0, `ev_ts`=0, `overflow`=0, `drop_count`=0; `ts`, `pending`, `pend_ts`, and the FIFO pointers and occupancy are all 0.
- **Reset deassertion:** the first edge after release is treated as a normal cycle.
- **Latency:**
  - A spike sampled at edge E sets `pending` after E.
  - It is pushed at E+1 if it wins arbitration and the FIFO has room.
  - `ev_valid`=1 after E+1, i.e. 2 cycles minimum.
- **Timestamp:** `ev_ts` equals the `ts` value present in the cycle before edge E (the capture cycle).
- **Throughput:** 1 event/cycle, sustained with `ev_ready` held high.
- **Reset mid-operation:** all queued and pending events are discarded and nothing is emitted after release.

## Configuration
- `SPIKE_AER_TIMESTAMP_EN` defined:
  - The timestamp counter, `pend_ts` storage and the FIFO ts field are present.
  - `ev_ts` behaves as above.
- `SPIKE_AER_TIMESTAMP_EN` undefined:
  - The counter, `pend_ts` and the FIFO ts field are removed.
  - `ev_ts` is tied to 0 and the port remains for pin compatibility.
  - All other behaviour, including latency, is identical.

## Test plan
- **Reset:** assert `rst_n`=0 with `spike_in`=3'b111 -> all outputs 0. Release and hold `spike_in`=0 for 10 cycles -> `ev_valid` stays 0.
- **Single spike:** `spike_in`=3'b010 for one cycle with `ts`=5, `ev_ready`=1 -> `ev_valid` high exactly 2 edges later for one cycle, with `ev_addr`=1, `ev_ts`=5.
- **Simultaneous spikes:** `spike_in`=3'b111 for one cycle at `ts`=20 -> three events in consecutive cycles with addr 0,1,2, all with `ev_ts`=20, and `drop_count`=0.
- **Backpressure and full:**
  - Stimulus: `ev_ready`=0; neuron 0 spikes every cycle for 8 cycles.
  - Required response: the FIFO fills with 4 events and `pending[0]` holds a 5th.
  - The remaining spikes are dropped: `drop_count`=3, `overflow`=1.
  - Head held stable at addr 0, ts of the first spike.
  - Raising `ev_ready` then drains the 5 events in order.
- **Saturation and clear:** force 300 drops -> `drop_count`=255. Pulse `clear` with no drop that cycle -> `drop_count`=0, `overflow`=0.
- **Timestamp wrap:** spikes captured at `ts`=255 and `ts`=0 on neuron 2 -> events read back in order with ts 255 then 0.
- **Macro off:** rerun the simultaneous-spikes test -> same addresses and cycle timing, with `ev_ts`=0 throughout.
